dom_rand_gen: RTL and testbench

Fresh-randomness source for the 3rd-order DOM AND gadget. It produces the six mask bits Z0..Z5 that the gadget consumes each evaluation cycle. A 32-bit maximal-length LFSR is advanced six steps per cycle, with seed load, warm-up and consume handshakes. The block sits directly upstream of the gadget's Z inputs and holds a word until the gadget side consumes it.

---
 rtl/dom_rand_gen.sv | 134 +++++++++++++
 tb/tb_dom_rand_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dom_rand_gen.sv
//------------------------------------------------------------------------------
// dom_rand_gen : six-bit fresh-randomness source (32-bit LFSR, 6 steps/advance)
// Optional reseed request counter built when DOM_RAND_RESEED_REQ_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dom_rand_gen #(
   parameter int WARMUP_CYCLES   = 64,
   parameter int RESEED_INTERVAL = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] seed_i,
   input  logic        seed_valid_i,
   output logic        seed_ready_o,
   input  logic        rand_ready_i,
   output logic        rand_valid_o,
   output logic        Z0_o,
   output logic        Z1_o,
   output logic        Z2_o,
   output logic        Z3_o,
   output logic        Z4_o,
   output logic        Z5_o,
   output logic        reseed_req_o
);

   localparam logic [1:0] c_IDLE      = 2'd0;
   localparam logic [1:0] c_WARMUP    = 2'd1;
   localparam logic [1:0] c_RUN       = 2'd2;
   localparam logic [7:0] c_WARM_LAST = 8'(WARMUP_CYCLES - 1);

   logic [1:0]  r_state;
   logic [31:0] r_s;
   logic [7:0]  r_cnt;
   logic [5:0]  r_z;

   logic [31:0] w_s_adv;
   logic [5:0]  w_z_adv;
   logic [31:0] w_seed_load;
   logic        w_seed_ready;
   logic        w_seed_hs;
   logic        w_valid;

   // Six unrolled LFSR steps; feedback bit of step k becomes Z bit k.
   always_comb begin : p_advance
      logic v_fb;
      w_s_adv = r_s;
      w_z_adv = '0;
      v_fb    = 1'b0;
      for (int k = 0; k < 6; k++) begin
         v_fb       = w_s_adv[31] ^ w_s_adv[21] ^ w_s_adv[1] ^ w_s_adv[0];
         w_z_adv[k] = v_fb;
         w_s_adv    = {w_s_adv[30:0], v_fb};
      end
   end

   assign w_seed_load  = (seed_i == 32'h0) ? 32'h0000_0001 : seed_i;
   assign w_seed_ready = (r_state != c_WARMUP);
   assign w_seed_hs    = seed_valid_i & w_seed_ready;
   assign w_valid      = (r_state == c_RUN);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= c_IDLE;
         r_s     <= '0;
         r_cnt   <= '0;
         r_z     <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_seed_hs) begin
                  r_s     <= w_seed_load;
                  r_cnt   <= '0;
                  r_state <= c_WARMUP;
               end
            end
            c_WARMUP: begin
               r_s   <= w_s_adv;
               r_z   <= w_z_adv;
               r_cnt <= r_cnt + 8'd1;
               if (r_cnt == c_WARM_LAST) begin
                  r_state <= c_RUN;
               end
            end
            c_RUN: begin
               // A new seed wins over a simultaneous consume.
               if (w_seed_hs) begin
                  r_s     <= w_seed_load;
                  r_cnt   <= '0;
                  r_state <= c_WARMUP;
               end else if (rand_ready_i) begin
                  r_s <= w_s_adv;
                  r_z <= w_z_adv;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

`ifdef DOM_RAND_RESEED_REQ_EN
   localparam logic [15:0] c_RESEED_MAX = 16'(RESEED_INTERVAL);

   logic [15:0] r_rs_cnt;
   logic        w_run_adv;

   assign w_run_adv = w_valid & rand_ready_i & ~w_seed_hs;

   always_ff @(posedge clk_i) begin
      if (rst_i || w_seed_hs) begin
         r_rs_cnt <= '0;
      end else if (w_run_adv && (r_rs_cnt != c_RESEED_MAX)) begin
         r_rs_cnt <= r_rs_cnt + 16'd1;
      end
   end

   assign reseed_req_o = (r_rs_cnt == c_RESEED_MAX);
`else
   assign reseed_req_o = 1'b0;
`endif

   assign seed_ready_o = w_seed_ready;
   assign rand_valid_o = w_valid;
   assign Z0_o         = r_z[0] & w_valid;
   assign Z1_o         = r_z[1] & w_valid;
   assign Z2_o         = r_z[2] & w_valid;
   assign Z3_o         = r_z[3] & w_valid;
   assign Z4_o         = r_z[4] & w_valid;
   assign Z5_o         = r_z[5] & w_valid;

endmodule

`default_nettype wire

// File: tb/tb_dom_rand_gen.sv
//------------------------------------------------------------------------------
// tb_dom_rand_gen : known-answer checks plus randomized run against a model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dom_rand_gen;

   localparam int TW = 5;
   localparam int RI = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Main DUT
   logic        rst = 1'b1, seed_valid = 1'b0, rand_ready = 1'b0;
   logic [31:0] seed = '0;
   logic        seed_ready, rand_valid, rreq;
   logic        z0, z1, z2, z3, z4, z5;

   dom_rand_gen #(.WARMUP_CYCLES(TW), .RESEED_INTERVAL(RI)) u_dut (
      .clk_i(clk), .rst_i(rst), .seed_i(seed), .seed_valid_i(seed_valid),
      .seed_ready_o(seed_ready), .rand_ready_i(rand_ready), .rand_valid_o(rand_valid),
      .Z0_o(z0), .Z1_o(z1), .Z2_o(z2), .Z3_o(z3), .Z4_o(z4), .Z5_o(z5),
      .reseed_req_o(rreq)
   );

   // Known-answer DUT with a single warm-up advance
   logic        k_rst = 1'b1, k_sv = 1'b0, k_ready = 1'b0;
   logic [31:0] k_seed = '0;
   logic        k_seed_ready, k_valid, k_rreq;
   logic        k0, k1, k2, k3, k4, k5;

   dom_rand_gen #(.WARMUP_CYCLES(1), .RESEED_INTERVAL(RI)) u_kat (
      .clk_i(clk), .rst_i(k_rst), .seed_i(k_seed), .seed_valid_i(k_sv),
      .seed_ready_o(k_seed_ready), .rand_ready_i(k_ready), .rand_valid_o(k_valid),
      .Z0_o(k0), .Z1_o(k1), .Z2_o(k2), .Z3_o(k3), .Z4_o(k4), .Z5_o(k5),
      .reseed_req_o(k_rreq)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: six steps of x^32+x^22+x^2+x+1, returns {z[5:0], s_next}
   function automatic logic [37:0] ref_adv(input logic [31:0] s_in);
      logic [31:0] s;
      logic [5:0]  z;
      logic        f;
      s = s_in;
      z = '0;
      for (int k = 0; k < 6; k++) begin
         f    = s[31] ^ s[21] ^ s[1] ^ s[0];
         z[k] = f;
         s    = (s << 1) | {31'b0, f};
      end
      return {z, s};
   endfunction

   // Model: phase 0 idle, 1 warm-up, 2 run
   int          m_phase = 0;
   int          m_left  = 0;
   int          m_used  = 0;
   logic [31:0] m_s     = '0;
   logic [5:0]  m_z     = '0;

   task automatic model_edge(input logic r, input logic sv, input logic [31:0] sd, input logic rd);
      logic [37:0] a;
      a = ref_adv(m_s);
      if (r) begin
         m_phase = 0; m_s = '0; m_z = '0; m_used = 0; m_left = 0;
      end else if (m_phase != 1 && sv) begin
         m_s     = (sd == 0) ? 32'd1 : sd;
         m_phase = 1;
         m_left  = TW;
         m_used  = 0;
      end else if (m_phase == 1) begin
         {m_z, m_s} = a;
         m_left--;
         if (m_left == 0) m_phase = 2;
      end else if (m_phase == 2 && rd) begin
         {m_z, m_s} = a;
         if (m_used < RI) m_used++;
      end
   endtask

   task automatic step(input logic r, input logic sv, input logic [31:0] sd, input logic rd);
      logic exp_rreq;
      rst = r; seed_valid = sv; seed = sd; rand_ready = rd;
      @(posedge clk);
      model_edge(r, sv, sd, rd);
      #1;
`ifdef DOM_RAND_RESEED_REQ_EN
      exp_rreq = (m_used == RI);
`else
      exp_rreq = 1'b0;
`endif
      chk("seed_ready", {31'b0, seed_ready}, {31'b0, m_phase != 1});
      chk("rand_valid", {31'b0, rand_valid}, {31'b0, m_phase == 2});
      chk("z_word", {26'b0, z5, z4, z3, z2, z1, z0}, {26'b0, (m_phase == 2) ? m_z : 6'b0});
      chk("reseed_req", {31'b0, rreq}, {31'b0, exp_rreq});
   endtask

   logic [37:0] kat_next;

   initial begin
      // ---------------- known-answer sequence ----------------
      kat_next = ref_adv(32'h0000_006D);
      @(posedge clk); #1;
      chk("kat_reset_ready", {31'b0, k_seed_ready}, 32'd1);
      chk("kat_reset_valid", {31'b0, k_valid}, 32'd0);
      k_rst = 1'b0; k_sv = 1'b1; k_seed = 32'h0000_0001;
      @(posedge clk); #1;
      k_sv = 1'b0;
      chk("kat_warm_ready", {31'b0, k_seed_ready}, 32'd0);
      chk("kat_warm_valid", {31'b0, k_valid}, 32'd0);
      @(posedge clk); #1;
      chk("kat_seed1_valid", {31'b0, k_valid}, 32'd1);
      chk("kat_seed1_z", {26'b0, k5, k4, k3, k2, k1, k0}, 32'h2D);
      k_ready = 1'b1;
      @(posedge clk); #1;
      k_ready = 1'b0;
      chk("kat_seed1_next", {26'b0, k5, k4, k3, k2, k1, k0}, {26'b0, kat_next[37:32]});
      k_sv = 1'b1; k_seed = 32'h0; k_ready = 1'b1;
      @(posedge clk); #1;
      k_sv = 1'b0; k_ready = 1'b0;
      chk("kat_reseed_valid", {31'b0, k_valid}, 32'd0);
      @(posedge clk); #1;
      chk("kat_seed0_z", {26'b0, k5, k4, k3, k2, k1, k0}, 32'h2D);
      k_ready = 1'b1;
      @(posedge clk); #1;
      k_ready = 1'b0;
      chk("kat_seed0_next", {26'b0, k5, k4, k3, k2, k1, k0}, {26'b0, kat_next[37:32]});
      k_rst = 1'b1;

      // ---------------- main DUT: directed ----------------
      step(1, 0, 0, 0);
      step(1, 1, 32'h1234_5678, 1);
      step(0, 1, 32'hCAFE_F00D, 0);
      for (int i = 0; i < TW; i++) step(0, 1, 32'h1111_1111, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
      step(0, 1, 32'hA5A5_0001, 1);
      for (int i = 0; i < TW + 2; i++) step(0, 0, 0, 1);
      step(0, 1, 32'h0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(1, 1, 32'h7, 1);
      step(0, 1, 32'h0BAD_BEEF, 0);
      for (int i = 0; i < TW + 3; i++) step(0, 0, 0, 1);
      step(1, 1, 32'h9, 1);
      step(0, 0, 0, 0);

      // ---------------- main DUT: randomized ----------------
      for (int i = 0; i < 600; i++) begin
         logic r, sv, rd;
         logic [31:0] sd;
         r  = ($urandom_range(0, 59) == 0);
         sv = ($urandom_range(0, 14) == 0);
         rd = ($urandom_range(0, 1) == 1);
         sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         step(r, sv, sd, rd);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
